sram_bank: RTL
==============

# sram_bank

Parametrised single-port byte-lane SRAM bank with a valid/ready request interface, a configurable read pipeline and a hardware zero-fill sequencer. Generalises the fixed 4-lane scratch SRAM to any lane count, and guarantees known contents after reset or on demand. Sits between tracer compute units and on-chip storage such as framebuffer tiles and BVH/node caches.

## Interface
- `BYTES`, default 4: byte lanes per word, ≥1; word width is `BYTES*8`.
- `DEPTH`, default 1024: words, ≥2, need not be a power of two.
- `READ_LAT`, default 1: read latency in cycles, 1 or 2.
- `INIT_ZERO`, default 1: 1 runs the zero-fill after reset; 0 comes up ready with contents undefined.
- `AW`, derived: `$clog2(DEPTH)`.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  BYTES*8  write data; lane i is bits [8i+7:8i].
- `req_be`  in  BYTES  per-lane write enable.
- `clr_req`  in  1  single-cycle pulse that starts a zero-fill.
- `busy`  out  1  high while zero-fill runs.
- `rsp_valid`  out  1  one-cycle pulse, read data valid.
- `rsp_rdata`  out  BYTES*8  read data; holds its value between pulses.

## Operation
- FSM states:
  - CLEAR: sweep counter writes all-zero, all lanes, one word per cycle; `req_ready`=0, `busy`=1.
  - READY: `req_ready`=1, `busy`=0.
- Reset: the state is CLEAR if `INIT_ZERO`=1, else READY. The counter resets to 0. `rsp_valid`, `rsp_rdata` and the pipeline valid bits reset to 0. The memory array is not reset.
- CLEAR → READY in the cycle after the counter writes address `DEPTH-1`. A sweep takes exactly `DEPTH` cycles.
- READY → CLEAR on `clr_req`. A request accepted in that same cycle still executes; its write is overwritten by the sweep.
- `clr_req` during CLEAR restarts the counter at 0.
- Write (accepted, `req_we`=1): only lanes with `req_be[i]`=1 update. `req_be`=0 is a legal no-op. No response is produced.
- Read (accepted, `req_we`=0): returns the full word. `req_be` is ignored.
- Address ≥ `DEPTH` (non-power-of-two depth): write is dropped; read returns all-zero with a normal `rsp_valid` pulse.
- Read pipeline: accepted reads already in flight when CLEAR starts still complete and return pre-clear data.
- No response backpressure. The consumer must always sink `rsp_valid`.

## Timing
- One request per cycle in READY, back-to-back, with no bubbles.
- A read accepted at edge N gives `rsp_valid`=1 and data in the cycle after edge N+`READ_LAT`.
- Read-after-write to the same address in consecutive cycles returns the new data. The write commits at its accept edge, before the read samples the array.
- `READ_LAT`=2 adds one output register stage for the data and its valid bit.
- Zero-fill: `busy` rises in the cycle after the `clr_req` edge and stays high for `DEPTH` cycles. `req_ready` is the exact complement of `busy`.
- Reset asserted mid-operation: all in-flight reads are discarded with no `rsp_valid`. The sweep restarts from 0 on release when `INIT_ZERO`=1.

## Structure
- `sram_pkg` contains:
  - `state_t` enum {CLEAR, READY};
  - localparam helper `LAT_MAX`=2.
- Sub-module `sram_core`: a pure array with a registered read and per-lane write enables (a generate loop over `BYTES`). No reset, no handshake.
- `sram_bank` contains the FSM, the sweep counter, the address-range check, the request mux (sweep versus request), the latency pipeline and the response registers.

## Test plan
All cases use `BYTES`=4 and `DEPTH`=16 unless noted.

- Reset, `INIT_ZERO`=1:
  - `busy`=1 for exactly 16 cycles, then `req_ready`=1.
  - Reading addresses 0–15 returns 0x00000000 each.
- Byte enables:
  - Write 0xAABBCCDD to address 3 with `be`=0xF, then 0x11223344 with `be`=0x5.
  - Read address 3 returns 0xAA22CC44.
- Latency: back-to-back reads of addresses 1, 2, 3, for each `READ_LAT` in {1, 2}.
  - Three consecutive `rsp_valid` pulses, starting 1 or 2 cycles after the first accept.
  - Data arrives in order.
- Read-after-write:
  - Write 0x12345678 to address 5, then a read of address 5 in the next cycle.
  - Returns 0x12345678.
- Clear mid-traffic:
  - Fill all words with 0xFFFFFFFF. Issue a read of address 7 together with `clr_req`.
  - The read returns 0xFFFFFFFF. `busy` is high for 16 cycles, after which address 7 reads 0.
- Out-of-range, `DEPTH`=12: write 0xDEADBEEF to address 13, then read address 13.
  - The read returns 0.
  - Addresses 0–11 are unchanged.
- Async reset:
  - Assert `rst_n`=0 one cycle after a read is accepted.
  - No `rsp_valid` ever appears for that read, and `rsp_rdata`=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Purpose: shared types and constants for the sram_bank slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: state_t (CLEAR / READY) for the bank FSM, LAT_MAX read-pipeline bound.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Deepest read pipeline the bank supports (array register + one output stage).
  localparam int LAT_MAX = 2;

endpackage

// File: rtl/sram_core.sv
// Purpose: raw byte-lane storage array with registered read, no reset, no handshake.
// Latency: read data valid the cycle after the edge that samples re_i.
// Backpressure: none; every enabled access is performed on the edge it is presented.
//
// Ports:
//   clk      clock
//   we_i     write strobe, qualified per lane by be_i
//   be_i     per-lane write enable (BYTES bits)
//   addr_i   word address, caller guarantees addr_i < DEPTH when we_i/re_i set
//   wdata_i  write data, lane i is bits [8i+7:8i]
//   re_i     read strobe; rdata_o holds its last value when low
//   rdata_o  registered read data
module sram_core #(
  parameter int BYTES = 4,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [BYTES-1:0]   be_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [BYTES*8-1:0] wdata_i,
  input  logic               re_i,
  output logic [BYTES*8-1:0] rdata_o
);

  // One independent 8-bit array per lane so each lane has a single writer.
  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i && be_i[i]) begin
        mem[addr_i] <= wdata_i[8*i +: 8];
      end
      if (re_i) begin
        rd_q <= mem[addr_i];
      end
    end

    assign rdata_o[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/sram_bank.sv
// Purpose: byte-lane SRAM bank with valid/ready requests and a hardware zero-fill sweep.
// Latency: read accepted at edge N responds in the cycle after edge N+READ_LAT; writes commit at accept.
// Backpressure: req_ready low only while the zero-fill runs; responses cannot be stalled.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_we selects write (1) or read (0)
//   req_addr, req_wdata   word address and write data (lane i = bits [8i+7:8i])
//   req_be                per-lane write enable, ignored for reads
//   clr_req               one-cycle pulse that (re)starts the zero-fill
//   busy                  high while the zero-fill runs (complement of req_ready)
//   rsp_valid, rsp_rdata  one-cycle read-data pulse; data holds between pulses
module sram_bank
  import sram_pkg::*;
#(
  parameter int BYTES     = 4,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 1,
  parameter int INIT_ZERO = 1,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [AW-1:0]      req_addr,
  input  logic [BYTES*8-1:0] req_wdata,
  input  logic [BYTES-1:0]   req_be,
  input  logic               clr_req,
  output logic               busy,
  output logic               rsp_valid,
  output logic [BYTES*8-1:0] rsp_rdata
);

  localparam int            DW        = BYTES * 8;
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam state_t        RST_STATE = (INIT_ZERO != 0) ? CLEAR : READY;

  // ---------------------------------------------------------------- FSM / sweep
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (clr_req) begin
          cnt_d = '0;                 // a new clear request restarts the sweep
        end else if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        req_ready = 1'b1;
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // ---------------------------------------------------------------- request mux
  logic             accept, in_range, rd_fire;
  logic             core_we, core_re;
  logic [BYTES-1:0] core_be;
  logic [AW-1:0]    core_addr;
  logic [DW-1:0]    core_wdata, core_rdata;

  assign accept   = req_valid && req_ready;
  // Only meaningful for non-power-of-two depths; constant-true otherwise.
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign rd_fire  = accept && !req_we;

  // The sweep owns the array while busy; requests cannot be accepted then.
  assign core_we    = busy || (accept && req_we && in_range);
  assign core_be    = busy ? '1 : req_be;
  assign core_addr  = busy ? cnt_q : req_addr;
  assign core_wdata = busy ? '0 : req_wdata;
  assign core_re    = rd_fire && in_range;

  sram_core #(
    .BYTES (BYTES),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk     (clk),
    .we_i    (core_we),
    .be_i    (core_be),
    .addr_i  (core_addr),
    .wdata_i (core_wdata),
    .re_i    (core_re),
    .rdata_o (core_rdata)
  );

  // ---------------------------------------------------------------- read pipeline
  // Stage 1 tracks the read sitting in the array's output register. An
  // out-of-range read never touches the array, so its data is forced to zero.
  logic          s1_vld_q, s1_oor_q;
  logic [DW-1:0] s1_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_oor_q <= 1'b0;
    end else begin
      s1_vld_q <= rd_fire;
      s1_oor_q <= rd_fire && !in_range;
    end
  end

  assign s1_dat = s1_oor_q ? '0 : core_rdata;

  logic          out_vld;
  logic [DW-1:0] out_dat;

  if (READ_LAT >= LAT_MAX) begin : g_lat2
    logic          s2_vld_q;
    logic [DW-1:0] s2_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_dat_q <= s1_dat;
        end
      end
    end

    assign out_vld = s2_vld_q;
    assign out_dat = s2_dat_q;
  end else begin : g_lat1
    assign out_vld = s1_vld_q;
    assign out_dat = s1_dat;
  end

  // ---------------------------------------------------------------- response
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= out_vld;
      if (out_vld) begin
        rsp_rdata_q <= out_dat;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
